// File: rtl/playlist_sequencer.sv
// Playlist scheduler above PlayerCtrl: picks the song, handles end-of-song policy and the muted inter-track gap.
// Optional shuffle advance is compiled in with `define SHUFFLE_EN.
module playlist_sequencer #(
   parameter int         NUM_SONGS  = 4,
   parameter int         SEL_W      = 2,
   parameter int         GAP_CYCLES = 4,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             next_req,
   input  logic             prev_req,
   input  logic [1:0]       mode,
   input  logic             song_finished,
   output logic [SEL_W-1:0] song_sel,
   output logic             player_repeat,
   output logic             gap_mute,
   output logic             active,
   output logic [7:0]       track_count
);

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SONGS - 1);
   localparam logic [15:0]      GAP_LAST = 16'(GAP_CYCLES - 1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [15:0]      gap_q, gap_d;
   logic [7:0]       trk_q, trk_d;
   logic             fin_q;

   logic             fin_rise;
   logic             both_req;
   logic             step_fwd;
   logic             step_back;
   logic [SEL_W-1:0] skip_sel;
   logic [SEL_W-1:0] adv_sel;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] s);
      return (s == SEL_LAST) ? '0 : s + SEL_W'(1);
   endfunction

   function automatic logic [SEL_W-1:0] wrap_dec(input logic [SEL_W-1:0] s);
      return (s == '0) ? SEL_LAST : s - SEL_W'(1);
   endfunction

   assign fin_rise  = song_finished & ~fin_q;
   assign both_req  = next_req & prev_req;
   assign step_fwd  = next_req & ~prev_req;
   assign step_back = prev_req & ~next_req;
   assign skip_sel  = step_fwd ? wrap_inc(sel_q) : wrap_dec(sel_q);

`ifdef SHUFFLE_EN
   logic [7:0]       lfsr_q;
   logic [SEL_W-1:0] cand;

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   // Compare one bit wider so NUM_SONGS == 2**SEL_W is handled correctly.
   always_comb begin
      cand = lfsr_q[SEL_W-1:0];
      if ({1'b0, cand} >= (SEL_W+1)'(NUM_SONGS)) cand = cand - SEL_W'(NUM_SONGS);
      if (cand == sel_q) cand = wrap_inc(sel_q);
      adv_sel = (mode == 2'b00) ? wrap_inc(sel_q) : cand;
   end
`else
   logic unused_seed;
   assign unused_seed = ^LFSR_SEED;
   assign adv_sel     = wrap_inc(sel_q);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         gap_q   <= '0;
         trk_q   <= '0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         gap_q   <= gap_d;
         trk_q   <= trk_d;
         fin_q   <= song_finished;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      gap_d   = gap_q;
      trk_d   = trk_q;
      case (state_q)
         IDLE: begin
            if (!stop && !both_req) begin
               if (step_fwd || step_back) sel_d = skip_sel;
               else if (start)            state_d = PLAY;
            end
         end
         PLAY: begin
            if (stop) begin
               state_d = IDLE;
            end else if (!both_req) begin
               if (step_fwd || step_back) begin
                  sel_d   = skip_sel;
                  state_d = GAP;
                  gap_d   = '0;
               end else if (fin_rise) begin
                  trk_d = sat_inc8(trk_q);
                  if (mode == 2'b10) begin
                     state_d = PLAY;
                  end else if (mode == 2'b00 && sel_q == SEL_LAST) begin
                     sel_d   = '0;
                     state_d = IDLE;
                  end else begin
                     sel_d   = adv_sel;
                     state_d = GAP;
                     gap_d   = '0;
                  end
               end
            end
         end
         GAP: begin
            // Simultaneous next+prev is ignored, so the gap keeps counting.
            if (stop) begin
               state_d = IDLE;
            end else if (step_fwd || step_back) begin
               sel_d = skip_sel;
               gap_d = '0;
            end else if (gap_q == GAP_LAST) begin
               state_d = PLAY;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign song_sel      = sel_q;
   assign track_count   = trk_q;
   assign active        = (state_q != IDLE);
   assign gap_mute      = (state_q != PLAY);
   assign player_repeat = (state_q == PLAY) && (mode == 2'b10);

endmodule

// File: tb/tb_playlist_sequencer.sv
// Directed bench for playlist_sequencer: expected outputs queued per step and compared after each edge.
module tb_playlist_sequencer;

   typedef enum int {S_IDLE, S_PLAY, S_GAP} st_t;

   typedef struct {
      string      tag;
      logic [1:0] sel;
      logic       act;
      logic       mute;
      logic       rep;
      logic [7:0] trk;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0, stop = 1'b0, next_req = 1'b0, prev_req = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       song_finished = 1'b0;
   logic [1:0] song_sel;
   logic       player_repeat, gap_mute, active;
   logic [7:0] track_count;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   trk = 0;
   logic [1:0] cur = 2'd0;
   logic [1:0] prv_sel;
   logic [7:0] m_lfsr;

   playlist_sequencer #(.NUM_SONGS(4), .SEL_W(2), .GAP_CYCLES(4), .LFSR_SEED(8'hA5)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .next_req(next_req),
      .prev_req(prev_req), .mode(mode), .song_finished(song_finished),
      .song_sel(song_sel), .player_repeat(player_repeat), .gap_mute(gap_mute),
      .active(active), .track_count(track_count));

   always #5 clk = ~clk;

   // Reference shuffle LFSR (Fibonacci, taps 8,6,5,4), stepping every clock.
   always @(posedge clk) begin
      if (reset) m_lfsr <= 8'hA5;
      else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   function automatic logic [1:0] inc(input logic [1:0] s);
      return (s == 2'd3) ? 2'd0 : s + 2'd1;
   endfunction

   function automatic logic [1:0] dec(input logic [1:0] s);
      return (s == 2'd0) ? 2'd3 : s - 2'd1;
   endfunction

   function automatic logic [1:0] auto_next(input logic [1:0] s);
`ifdef SHUFFLE_EN
      logic [1:0] c;
      c = m_lfsr[1:0];
      if (c == s) c = inc(s);
      return c;
`else
      return inc(s);
`endif
   endfunction

   function automatic int sat(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   task automatic check_out();
      exp_t e;
      logic [12:0] got, want;
      e    = q.pop_front();
      got  = {song_sel, active, gap_mute, player_repeat, track_count};
      want = {e.sel, e.act, e.mute, e.rep, e.trk};
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got sel=%0d act=%0b mute=%0b rep=%0b trk=%0d want sel=%0d act=%0b mute=%0b rep=%0b trk=%0d",
                e.tag, song_sel, active, gap_mute, player_repeat, track_count,
                e.sel, e.act, e.mute, e.rep, e.trk);
      end
   endtask

   task automatic step(input logic st, input logic sp, input logic nx, input logic pv,
                       input logic fn, input string tag, input st_t est,
                       input logic [1:0] esel, input int etrk);
      exp_t e;
      start = st; stop = sp; next_req = nx; prev_req = pv; song_finished = fn;
      e.tag  = tag;
      e.sel  = esel;
      e.act  = (est != S_IDLE);
      e.mute = (est != S_PLAY);
      e.rep  = (est == S_PLAY) && (mode == 2'b10);
      e.trk  = etrk[7:0];
      q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0; stop = 1'b0; next_req = 1'b0; prev_req = 1'b0;
      check_out();
   endtask

   task automatic gap_then_play(input string tag);
      for (int g = 0; g < 3; g++) step(0, 0, 0, 0, 0, tag, S_GAP, cur, trk);
      step(0, 0, 0, 0, 0, tag, S_PLAY, cur, trk);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      step(0, 0, 0, 0, 0, "reset", S_IDLE, 2'd0, 0);
      reset = 1'b0;

      // Once-through playlist ending in IDLE
      mode = 2'b00;
      step(1, 0, 0, 0, 0, "t1_start", S_PLAY, 2'd0, 0);
      for (int k = 1; k <= 3; k++) begin
         trk = sat(trk);
         cur = inc(cur);
         step(0, 0, 0, 0, 1, "t1_fin", S_GAP, cur, trk);
         gap_then_play("t1_gap");
      end
      trk = sat(trk);
      cur = 2'd0;
      step(0, 0, 0, 0, 1, "t1_end", S_IDLE, cur, trk);
      step(0, 0, 0, 0, 0, "t1_idle", S_IDLE, cur, trk);
      step(0, 0, 0, 0, 1, "idle_fin_ignored", S_IDLE, cur, trk);
      step(0, 0, 0, 0, 0, "idle_fin_low", S_IDLE, cur, trk);

      // Repeat-all wrap from the last song
      mode = 2'b01;
      cur = dec(cur);
      step(0, 0, 0, 1, 0, "t2_prev_idle", S_IDLE, cur, trk);
      step(1, 0, 0, 0, 0, "t2_start", S_PLAY, cur, trk);
      trk = sat(trk);
      cur = auto_next(cur);
      step(0, 0, 0, 0, 1, "t2_fin", S_GAP, cur, trk);
      gap_then_play("t2_gap");

      // Repeat-one with song_finished held high
      mode = 2'b10;
      step(0, 0, 0, 0, 0, "t3_repeat", S_PLAY, cur, trk);
      trk = sat(trk);
      step(0, 0, 0, 0, 1, "t3_fin", S_PLAY, cur, trk);
      for (int i = 0; i < 49; i++) step(0, 0, 0, 0, 1, "t3_hold", S_PLAY, cur, trk);
      step(0, 0, 0, 0, 0, "t3_low", S_PLAY, cur, trk);
      mode = 2'b01;

      // Event priority
      step(0, 1, 0, 0, 0, "t4_stop", S_IDLE, cur, trk);
      cur = dec(cur);
      step(0, 0, 0, 1, 0, "t4_prev", S_IDLE, cur, trk);
      step(1, 0, 0, 0, 0, "t4_start", S_PLAY, cur, trk);
      step(0, 0, 1, 1, 0, "t4_both", S_PLAY, cur, trk);
      step(0, 0, 1, 1, 1, "t4_both_fin", S_PLAY, cur, trk);
      step(0, 0, 0, 0, 0, "t4_fin_low", S_PLAY, cur, trk);
      step(0, 1, 1, 0, 0, "t4_stop_next", S_IDLE, cur, trk);

      // Skips during GAP, stop in GAP, reset in GAP
      step(1, 0, 0, 0, 0, "t5_start", S_PLAY, cur, trk);
      cur = inc(cur);
      step(0, 0, 1, 0, 0, "t5_next", S_GAP, cur, trk);
      step(0, 0, 0, 0, 0, "t5_gap1", S_GAP, cur, trk);
      step(0, 0, 0, 0, 0, "t5_gap2", S_GAP, cur, trk);
      cur = inc(cur);
      step(0, 0, 1, 0, 0, "t5_next_gap", S_GAP, cur, trk);
      gap_then_play("t5_restart");
      cur = dec(cur);
      step(0, 0, 0, 1, 0, "t5_prev", S_GAP, cur, trk);
      step(0, 0, 0, 0, 0, "t5_gap", S_GAP, cur, trk);
      step(0, 1, 0, 0, 0, "t5_stop_gap", S_IDLE, cur, trk);
      step(1, 0, 0, 0, 0, "t5_start2", S_PLAY, cur, trk);
      trk = sat(trk);
      cur = auto_next(cur);
      step(0, 0, 0, 0, 1, "t5_fin", S_GAP, cur, trk);
      step(0, 0, 0, 0, 0, "t5_gap3", S_GAP, cur, trk);
      reset = 1'b1;
      trk = 0;
      cur = 2'd0;
      step(0, 0, 0, 0, 0, "t5_reset", S_IDLE, cur, trk);
      reset = 1'b0;

      // track_count saturation
      mode = 2'b10;
      step(1, 0, 0, 0, 0, "sat_start", S_PLAY, cur, trk);
      for (int i = 0; i < 260; i++) begin
         trk = sat(trk);
         step(0, 0, 0, 0, 1, "sat_fin", S_PLAY, cur, trk);
         step(0, 0, 0, 0, 0, "sat_low", S_PLAY, cur, trk);
      end

`ifdef SHUFFLE_EN
      // Shuffle advance never repeats a song and stays in range
      mode = 2'b01;
      for (int i = 0; i < 100; i++) begin
         prv_sel = cur;
         cur = auto_next(cur);
         step(0, 0, 0, 0, 1, "shuf_fin", S_GAP, cur, trk);
         checks++;
         assert (song_sel != prv_sel && song_sel < 2'd4) else begin
            errors++;
            $error("FAIL shuf_prop got sel=%0d prev=%0d want different and <4", song_sel, prv_sel);
         end
         gap_then_play("shuf_gap");
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
